// File: rtl/star_pkg.sv
// Shared definitions for the star display path: coordinate widths, screen limits, box-draw states.
// Optional macro STAR_BOX_CENTRE_MARK_EN adds the S_MARK state.
package star_pkg;

   localparam int XSZ_DEF = 8;
   localparam int YSZ_DEF = 7;
   localparam int X_MAX   = 159;
   localparam int Y_MAX   = 119;
   localparam logic [2:0] BOX_COLOUR_DEF = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LATCH  = 3'd1,
      S_TOP    = 3'd2,
      S_BOTTOM = 3'd3,
      S_LEFT   = 3'd4,
      S_RIGHT  = 3'd5,
`ifdef STAR_BOX_CENTRE_MARK_EN
      S_MARK   = 3'd6,
`endif
      S_DONE   = 3'd7
   } box_state_t;

endpackage

// File: rtl/line_stepper.sv
// Start/length/direction counter: after load, emits one coordinate per cycle for len cycles.
module line_stepper #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dir,
   input  logic [W-1:0] start,
   input  logic [W:0]   len,
   output logic [W-1:0] pos,
   output logic         last
);

   logic [W:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         pos <= '0;
         cnt <= '0;
      end else if (load) begin
         pos <= start;
         cnt <= len;
      end else if (cnt != '0) begin
         pos <= dir ? pos - W'(1) : pos + W'(1);
         cnt <= cnt - (W+1)'(1);
      end
   end

   // cnt holds the pixels still to emit including the current one
   assign last = (cnt == (W+1)'(1));

endmodule

// File: rtl/star_box_draw.sv
// Draws a rectangular outline around the star bounding box, one pixel per cycle, into the VGA adapter.
// Optional macro STAR_BOX_CENTRE_MARK_EN appends a single centre-mark pixel after the outline.
module star_box_draw
   import star_pkg::*;
#(
   parameter int         XSZ        = XSZ_DEF,
   parameter int         YSZ        = YSZ_DEF,
   parameter int         MARGIN     = 1,
   parameter logic [2:0] BOX_COLOUR = BOX_COLOUR_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           go_draw,
   input  logic [XSZ-1:0] x_left,
   input  logic [XSZ-1:0] x_right,
   input  logic [YSZ-1:0] y_top,
   input  logic [YSZ-1:0] y_bottom,
   output logic [XSZ-1:0] x_out,
   output logic [YSZ-1:0] y_out,
   output logic [2:0]     colour,
   output logic           plot,
   output logic           busy,
   output logic           done_draw,
   output logic           box_err,
   output box_state_t     dbg_state
);

   localparam int SW = (XSZ > YSZ) ? XSZ : YSZ;
   localparam logic [XSZ-1:0] MXS  = XSZ'(MARGIN);
   localparam logic [YSZ-1:0] MYS  = YSZ'(MARGIN);
   localparam logic [XSZ:0]   MX   = (XSZ+1)'(MARGIN);
   localparam logic [YSZ:0]   MY   = (YSZ+1)'(MARGIN);
   localparam logic [XSZ:0]   XLIM = (XSZ+1)'(X_MAX);
   localparam logic [YSZ:0]   YLIM = (YSZ+1)'(Y_MAX);
`ifdef STAR_BOX_CENTRE_MARK_EN
   localparam box_state_t AFTER_RIGHT = S_MARK;
`else
   localparam box_state_t AFTER_RIGHT = S_DONE;
`endif

   box_state_t state, nxt;
   logic [XSZ-1:0] xl_q, xr_q, l_c, r_c, x_cur, x_hold;
   logic [YSZ-1:0] yt_q, yb_q, t_c, b_c, t_p1, y_cur, y_hold;
   logic [XSZ:0]   r_full, wlen;
   logic [YSZ:0]   b_full, hlen, side_len;
   logic           err_c, en_bottom, en_sides, en_right;
   logic           ld, st_last;
   logic [SW-1:0]  ld_start, st_pos;
   logic [SW:0]    ld_len;
   logic           unused_ok;

   // Start/done handshake: go_draw is accepted only in S_IDLE; busy covers the whole draw and
   // drops in the S_DONE cycle, where done_draw pulses once with box_err valid alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         xl_q   <= '0;
         xr_q   <= '0;
         yt_q   <= '0;
         yb_q   <= '0;
         x_hold <= '0;
         y_hold <= '0;
      end else begin
         state  <= nxt;
         x_hold <= x_cur;
         y_hold <= y_cur;
         if (state == S_IDLE && go_draw) begin
            xl_q <= x_left;
            xr_q <= x_right;
            yt_q <= y_top;
            yb_q <= y_bottom;
         end
      end
   end

   // Outline limits are clamped to the screen; captured values stay stable for the whole draw
   assign l_c    = (xl_q >= MXS) ? xl_q - MXS : '0;
   assign t_c    = (yt_q >= MYS) ? yt_q - MYS : '0;
   assign r_full = {1'b0, xr_q} + MX;
   assign b_full = {1'b0, yb_q} + MY;
   assign r_c    = (r_full > XLIM) ? XLIM[XSZ-1:0] : r_full[XSZ-1:0];
   assign b_c    = (b_full > YLIM) ? YLIM[YSZ-1:0] : b_full[YSZ-1:0];

   assign err_c = (xl_q > xr_q) || (yt_q > yb_q) ||
                  ({1'b0, xr_q} > XLIM) || ({1'b0, yb_q} > YLIM);

   assign wlen      = {1'b0, r_c} - {1'b0, l_c} + (XSZ+1)'(1);
   assign hlen      = {1'b0, b_c} - {1'b0, t_c} + (YSZ+1)'(1);
   assign side_len  = hlen - (YSZ+1)'(2);
   assign t_p1      = t_c + YSZ'(1);
   assign en_bottom = (b_c != t_c);
   assign en_sides  = (hlen >= (YSZ+1)'(3));
   assign en_right  = en_sides && (r_c != l_c);

`ifdef STAR_BOX_CENTRE_MARK_EN
   logic [XSZ:0] cx_sum;
   logic [YSZ:0] cy_sum;
   assign cx_sum    = {1'b0, xl_q} + {1'b0, xr_q};
   assign cy_sum    = {1'b0, yt_q} + {1'b0, yb_q};
   assign unused_ok = ^{cx_sum[0], cy_sum[0], st_pos};
`else
   assign unused_ok = ^st_pos;
`endif

   always_comb begin
      nxt      = state;
      ld       = 1'b0;
      ld_start = '0;
      ld_len   = '0;
      case (state)
         S_IDLE:   if (go_draw) nxt = S_LATCH;
         S_LATCH:  nxt = err_c ? S_DONE : S_TOP;
         S_TOP:    if (st_last) nxt = en_bottom ? S_BOTTOM : (en_sides ? S_LEFT : AFTER_RIGHT);
         S_BOTTOM: if (st_last) nxt = en_sides ? S_LEFT : AFTER_RIGHT;
         S_LEFT:   if (st_last) nxt = en_right ? S_RIGHT : AFTER_RIGHT;
         S_RIGHT:  if (st_last) nxt = AFTER_RIGHT;
`ifdef STAR_BOX_CENTRE_MARK_EN
         S_MARK:   if (st_last) nxt = S_DONE;
`endif
         S_DONE:   nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
      // Reload the shared stepper on the same edge the previous segment ends: no gap cycles
      if (nxt != state) begin
         case (nxt)
            S_TOP, S_BOTTOM: begin
               ld       = 1'b1;
               ld_start = SW'(l_c);
               ld_len   = (SW+1)'(wlen);
            end
            S_LEFT, S_RIGHT: begin
               ld       = 1'b1;
               ld_start = SW'(t_p1);
               ld_len   = (SW+1)'(side_len);
            end
`ifdef STAR_BOX_CENTRE_MARK_EN
            S_MARK: begin
               ld       = 1'b1;
               ld_len   = (SW+1)'(1);
            end
`endif
            default: ld = 1'b0;
         endcase
      end
   end

   line_stepper #(.W(SW)) u_step (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .dir   (1'b0),
      .start (ld_start),
      .len   (ld_len),
      .pos   (st_pos),
      .last  (st_last)
   );

   always_comb begin
      plot  = 1'b0;
      x_cur = x_hold;
      y_cur = y_hold;
      case (state)
         S_TOP:    begin plot = 1'b1; x_cur = st_pos[XSZ-1:0]; y_cur = t_c; end
         S_BOTTOM: begin plot = 1'b1; x_cur = st_pos[XSZ-1:0]; y_cur = b_c; end
         S_LEFT:   begin plot = 1'b1; x_cur = l_c; y_cur = st_pos[YSZ-1:0]; end
         S_RIGHT:  begin plot = 1'b1; x_cur = r_c; y_cur = st_pos[YSZ-1:0]; end
`ifdef STAR_BOX_CENTRE_MARK_EN
         S_MARK:   begin plot = 1'b1; x_cur = cx_sum[XSZ:1]; y_cur = cy_sum[YSZ:1]; end
`endif
         default:  plot = 1'b0;
      endcase
   end

   assign x_out     = x_cur;
   assign y_out     = y_cur;
   assign colour    = BOX_COLOUR;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done_draw = (state == S_DONE);
   assign box_err   = (state == S_DONE) && err_c;
   assign dbg_state = state;

endmodule
